// File: rtl/rs_pkg.sv
// Shared reservation-station sizing and types used by the RS allocator and
// the dispatch stage.
package rs_pkg;

    localparam int RS_ENTRIES = 8;

    typedef logic [RS_ENTRIES-1:0]       rs_mask_t;
    typedef logic [$clog2(RS_ENTRIES):0] rs_count_t;

endpackage

// File: rtl/rs_slot_allocator_find_first_zero.sv
// Combinational lowest-zero picker: returns a one-hot vector marking the
// lowest-index clear bit of vec, or all zeros when vec is all ones.
module find_first_zero #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot
);

    // Adding one ripples through the trailing ones and lands on the first
    // zero; masking with ~vec keeps only that landing bit.
    logic [WIDTH-1:0] vec_inc;

    always_comb begin
        vec_inc = vec + WIDTH'(1);
        onehot  = ~vec & vec_inc;
    end

endmodule

// File: rtl/rs_slot_allocator.sv
// Reservation-station occupancy tracker: grants the lowest free slot each
// cycle as a one-hot vector and releases slots on issue or flush.
module rs_slot_allocator
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_ENTRIES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_req,
    output logic                         alloc_gnt,
    output logic [NUM_ENTRIES-1:0]       alloc_onehot,
    input  logic                         free_valid,
    input  logic [NUM_ENTRIES-1:0]       free_mask,
    input  logic                         flush,
    output logic [NUM_ENTRIES-1:0]       busy,
    output logic [$clog2(NUM_ENTRIES):0] count,
    output logic                         full,
    output logic                         empty,
    output logic                         free_err
);

    localparam int CW = $clog2(NUM_ENTRIES) + 1;

    if (!(NUM_ENTRIES == 2 || NUM_ENTRIES == 4 || NUM_ENTRIES == 8)) begin : g_bad_entries
        $error("rs_slot_allocator: NUM_ENTRIES must be 2, 4 or 8");
    end

    function automatic logic [CW-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [NUM_ENTRIES-1:0] eff_free;
    logic [NUM_ENTRIES-1:0] busy_nxt;
    logic [CW-1:0]          count_nxt;
    logic                   bad_free;

    // The picker sees the busy flop directly; this is the dispatch critical path.
    find_first_zero #(
        .WIDTH (NUM_ENTRIES)
    ) u_pick (
        .vec    (busy),
        .onehot (alloc_onehot)
    );

    always_comb begin
        full      = (count == CW'(NUM_ENTRIES));
        empty     = (count == '0);
        alloc_gnt = alloc_req & ~full;
        eff_free  = free_valid ? (free_mask & busy) : '0;
        bad_free  = free_valid & (|(free_mask & ~busy));
        busy_nxt  = (busy & ~eff_free) | (alloc_gnt ? alloc_onehot : '0);
        count_nxt = count + CW'(alloc_gnt) - popcount(eff_free);
        if (flush) begin
            busy_nxt  = '0;
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            count    <= '0;
            free_err <= 1'b0;
        end else begin
            busy  <= busy_nxt;
            count <= count_nxt;
            if (bad_free) begin
                free_err <= 1'b1;
            end
        end
    end

    a_count_matches_busy : assert property (@(posedge clk) disable iff (!rst_n)
        int'(count) == $countones(busy));
    a_onehot_pick : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(alloc_onehot));
    a_no_grant_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        alloc_gnt |-> !full);

endmodule
